fifo_wr_arbiter: RTL

- Round-robin write arbiter that shares one FIFO write port between N producers.
- Each producer offers words on a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to MAX_BURST words, then drives registered data and write-enable into the FIFO.
- It never overflows the FIFO: full_in and one_p_in gate every write decision.
- Sits between producer agents/blocks and the FIFO write side.

---
 rtl/fifo_arb_pkg.sv | 31 +++
 rtl/fifo_wr_arbiter_rr_picker.sv | 24 ++
 rtl/fifo_wr_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
// rr_pick is sized for the largest supported producer count.
package fifo_arb_pkg;

   typedef enum logic {IDLE, BURST} arb_state_t;

   localparam int unsigned DEF_DATA_W    = 32;
   localparam int unsigned DEF_MAX_BURST = 4;
   localparam int unsigned MAX_REQ       = 8;
   localparam int unsigned PICK_W        = 3;

   // First set bit of valid at or after ptr, wrapping modulo n; returns ptr on no hit.
   function automatic logic [PICK_W-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [PICK_W-1:0]  ptr,
                                                 input int unsigned        n);
      logic [PICK_W-1:0] idx;
      logic              found;
      int unsigned       k;
      idx   = ptr;
      found = 1'b0;
      for (int unsigned i = 0; i < MAX_REQ; i++) begin
         k = (32'(ptr) + i) % n;
         if (i < n && !found && valid[k[PICK_W-1:0]]) begin
            idx   = k[PICK_W-1:0];
            found = 1'b1;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational rotating-priority picker: first valid requester at or after ptr.
module rr_picker
   import fifo_arb_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   localparam int unsigned IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] valid,
   input  logic [IDX_W-1:0] ptr,
   output logic             hit,
   output logic [IDX_W-1:0] idx
);

   logic [MAX_REQ-1:0] valid_ext;
   logic [PICK_W-1:0]  ptr_ext;
   logic [PICK_W-1:0]  pick;

   assign valid_ext = MAX_REQ'(valid);
   assign ptr_ext   = PICK_W'(ptr);
   assign pick      = rr_pick(valid_ext, ptr_ext, N_REQ);
   assign hit       = |valid;
   assign idx       = IDX_W'(pick);

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between N_REQ producers.
// Write data and enable are registered; full_in/one_p_in gate every accept.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned N_REQ     = 4,
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned MAX_BURST = DEF_MAX_BURST,
   localparam int unsigned IDX_W    = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid_in,
   input  logic [N_REQ*DATA_W-1:0] req_data_in,
   output logic [N_REQ-1:0]        req_ready_out,
   output logic [IDX_W-1:0]        grant_id_out,
   output logic                    busy_out,
   output logic [DATA_W-1:0]       data_to_fifo_out,
   output logic                    we_out,
   input  logic                    full_in,
   input  logic                    one_p_in
);

   localparam logic [IDX_W-1:0] LAST_ID    = IDX_W'(N_REQ - 1);
   localparam logic [3:0]       BURST_LAST = 4'(MAX_BURST - 1);

   arb_state_t        state, state_next;
   logic [IDX_W-1:0]  grant, grant_next;
   logic [IDX_W-1:0]  rr_ptr, rr_ptr_next;
   logic [IDX_W-1:0]  pick_idx;
   logic [3:0]        count, count_next;
   logic              pick_hit;
   logic              can_write;
   logic              accept;
   logic [DATA_W-1:0] grant_data;

   rr_picker #(.N_REQ(N_REQ)) u_picker (
      .valid (req_valid_in),
      .ptr   (rr_ptr),
      .hit   (pick_hit),
      .idx   (pick_idx)
   );

   // A write in flight consumes the last free place, so it blocks the next accept.
   assign can_write    = !full_in && !(we_out && one_p_in);
   assign grant_data   = req_data_in[grant*DATA_W +: DATA_W];
   assign busy_out     = (state == BURST);
   assign grant_id_out = grant;

   always_comb begin
      state_next    = state;
      grant_next    = grant;
      rr_ptr_next   = rr_ptr;
      count_next    = count;
      accept        = 1'b0;
      req_ready_out = '0;
      unique case (state)
         IDLE: begin
            if (pick_hit) begin
               state_next = BURST;
               grant_next = pick_idx;
               count_next = '0;
            end
         end
         BURST: begin
            accept               = req_valid_in[grant] && can_write && !rst;
            req_ready_out[grant] = accept;
            if (accept) begin
               count_next = count + 4'd1;
            end
            if ((accept && count == BURST_LAST) || !req_valid_in[grant]) begin
               state_next  = IDLE;
               count_next  = '0;
               rr_ptr_next = (grant == LAST_ID) ? '0 : grant + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         grant            <= '0;
         rr_ptr           <= '0;
         count            <= '0;
         we_out           <= 1'b0;
         data_to_fifo_out <= '0;
      end else begin
         state  <= state_next;
         grant  <= grant_next;
         rr_ptr <= rr_ptr_next;
         count  <= count_next;
         we_out <= accept;
         if (accept) begin
            data_to_fifo_out <= grant_data;
         end
      end
   end

endmodule
